period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_pkg.sv | 19 +
 rtl/period_meter_sync_2ff.sv | 33 +++
 rtl/period_meter.sv | 133 +++++++++++++
 tb/tb_period_meter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// period_meter_pkg
//   Shared clock-utilities definitions for the period meter and the clock
//   dividers: the measurement FSM state encoding and the synchronizer
//   settling depth used to qualify edges after reset.
package period_meter_pkg;

  // Measurement FSM states. The encodings are fixed because other clock
  // utilities decode them directly.
  typedef enum logic [1:0] {
    ARM     = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } meter_state_e;

  // Clock edges after reset release before the third edge-detect flop
  // holds a real sample of sig_in (two synchronizer stages plus s3).
  localparam logic [1:0] SYNC_PRIME_EDGES = 2'd3;

endpackage

// File: rtl/period_meter_sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer bringing an asynchronous single-bit signal into
//   the clk_in domain.
//   Ports:
//     clk_in - destination clock (rising edge)
//     rst    - asynchronous active-high reset, clears both stages
//     d      - asynchronous input
//     q      - synchronized output (second stage)
module sync_2ff (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // First stage may go metastable; the second stage gives it a full
  // cycle to resolve before anything downstream looks at it.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/period_meter.sv
// period_meter
//   Measures the rising-edge-to-rising-edge interval of a slow, asynchronous
//   signal in clk_in cycles. Each completed interval is reported on period
//   with a one-cycle valid pulse. If no edge arrives within MAX_COUNT cycles
//   the timeout level is raised and the next edge only restarts measurement.
//   Parameters:
//     MAX_COUNT - largest measurable period in clk_in cycles (4 .. 2^31-1)
//     N         - derived counter / period width (not overridable)
//   Ports:
//     clk_in  - system clock, all state on its rising edge
//     rst     - asynchronous active-high reset
//     sig_in  - signal to be measured, asynchronous to clk_in
//     period  - last measured interval in clk_in cycles
//     valid   - one-cycle pulse marking a new period value
//     timeout - high while no edge has arrived within MAX_COUNT cycles
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 32'd12_000_000,
  localparam int         N         = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         sig_in,
  output logic [N-1:0] period,
  output logic         valid,
  output logic         timeout
);

  localparam logic [N-1:0] MAX_CNT = N'(MAX_COUNT);

  meter_state_e state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;
  logic         s3_q, s3_d;
  logic [1:0]   prime_q, prime_d;

  logic         sync_q;
  logic         primed;
  logic         rise;
  logic [N-1:0] cnt_inc;

  sync_2ff u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (sig_in),
    .q      (sync_q)
  );

  // Right after reset s2 can go high while s3 still holds its reset 0,
  // which would look like an edge if sig_in was simply held high. Edges
  // are only trusted once s3 carries a genuine sample of sig_in.
  assign primed  = (prime_q == SYNC_PRIME_EDGES);
  assign rise    = sync_q & ~s3_q & primed;

  // cnt never exceeds MAX_COUNT-1, so this increment cannot overflow N bits.
  assign cnt_inc = cnt_q + N'(1);

  // Next-state logic for the measurement FSM and its registered outputs.
  // An edge always takes priority over the timeout check, so a period of
  // exactly MAX_COUNT is still reported.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    s3_d      = sync_q;
    prime_d   = primed ? prime_q : prime_q + 2'd1;

    case (state_q)
      ARM: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d = cnt_inc;
          valid_d  = 1'b1;
          cnt_d    = '0;
        end else if (cnt_inc == MAX_CNT) begin
          state_d   = TIMEOUT;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      TIMEOUT: begin
        // The interval that ended here overran, so it is not reported.
        if (rise) begin
          state_d   = MEASURE;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d   = ARM;
        cnt_d     = '0;
        timeout_d = 1'b0;
      end
    endcase
  end

  // All FSM state, edge-detect and output registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= ARM;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      s3_q      <= 1'b0;
      prime_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      s3_q      <= s3_d;
      prime_q   <= prime_d;
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
//   Directed bench for period_meter with MAX_COUNT = 16. A table of
//   square-wave patterns is replayed after a reset each, then hand-written
//   sequences cover latency, timeout recovery and reset mid-interval.
module tb_period_meter;

  localparam int unsigned MAX_COUNT = 16;

  logic       clk_in;
  logic       rst;
  logic       sig_in;
  logic [4:0] period;
  logic       valid;
  logic       timeout;

  int n_compared;
  int n_mismatched;

  // Per-run accumulators filled in by applyStimulus.
  int valid_seen;
  int timeout_seen;
  int overlap_seen;
  int bad_period;
  int last_period;
  int exp_period_g;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_valids;
    int exp_period;
    int exp_timeout;
  } vec_t;

  vec_t vecs [7];

  period_meter #(.MAX_COUNT(MAX_COUNT)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .sig_in  (sig_in),
    .period  (period),
    .valid   (valid),
    .timeout (timeout)
  );

  // 10 time-unit system clock.
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Counts one comparison and reports it if it does not hold.
  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives sig_in for one cycle (changed on the falling edge), then samples
  // the outputs just after the following rising edge.
  task automatic applyStimulus(input logic s);
    @(negedge clk_in);
    sig_in = s;
    @(posedge clk_in);
    #1;
    if (valid) begin
      valid_seen++;
      last_period = int'(period);
      if (int'(period) != exp_period_g) bad_period++;
    end
    if (timeout) timeout_seen++;
    if (valid && timeout) overlap_seen++;
  endtask

  task automatic clearCounts();
    valid_seen   = 0;
    timeout_seen = 0;
    overlap_seen = 0;
    bad_period   = 0;
    last_period  = 0;
  endtask

  // Synchronous-looking reset pulse followed by a few idle low cycles.
  task automatic applyReset();
    @(negedge clk_in);
    rst    = 1'b1;
    sig_in = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0);
    clearCounts();
  endtask

  task automatic drivePeriod(input int hi, input int lo);
    for (int i = 0; i < hi; i++) applyStimulus(1'b1);
    for (int i = 0; i < lo; i++) applyStimulus(1'b0);
  endtask

  initial begin
    int t;
    bit found;

    n_compared   = 0;
    n_mismatched = 0;
    exp_period_g = 0;
    clearCounts();

    // hi, lo, full periods, expected valids, expected period, timeout seen
    vecs[0] = '{4, 4, 4, 4, 8, 0};
    vecs[1] = '{1, 1, 6, 6, 2, 0};
    vecs[2] = '{8, 8, 2, 2, 16, 0};
    vecs[3] = '{9, 8, 2, 0, 0, 1};
    vecs[4] = '{3, 2, 3, 3, 5, 0};
    vecs[5] = '{1, 10, 2, 2, 11, 0};
    vecs[6] = '{2, 13, 2, 2, 15, 0};

    rst    = 1'b1;
    sig_in = 1'b0;
    #1;
    checkOutput("reset_period", int'(period), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_timeout", int'(timeout), 0);
    #20;
    @(negedge clk_in);
    rst = 1'b0;

    // Table-driven square waves: reps full periods plus one closing rise.
    for (int v = 0; v < 7; v++) begin
      applyReset();
      exp_period_g = vecs[v].exp_period;
      for (int r = 0; r < vecs[v].reps; r++) drivePeriod(vecs[v].hi, vecs[v].lo);
      drivePeriod(vecs[v].hi, 4);
      checkOutput($sformatf("v%0d_valids", v), valid_seen, vecs[v].exp_valids);
      checkOutput($sformatf("v%0d_bad_period", v), bad_period, 0);
      checkOutput($sformatf("v%0d_period", v), int'(period), vecs[v].exp_period);
      checkOutput($sformatf("v%0d_timeout_seen", v), int'(timeout_seen > 0), vecs[v].exp_timeout);
      checkOutput($sformatf("v%0d_overlap", v), overlap_seen, 0);
    end

    // First rise only arms; second rise reports exactly three edges later.
    applyReset();
    exp_period_g = 8;
    drivePeriod(4, 4);
    checkOutput("arm_no_valid", valid_seen, 0);
    applyStimulus(1'b1);
    checkOutput("lat_edge_k", int'(valid), 0);
    applyStimulus(1'b1);
    checkOutput("lat_edge_k1", int'(valid), 0);
    applyStimulus(1'b1);
    checkOutput("lat_edge_k2", int'(valid), 1);
    checkOutput("lat_period", int'(period), 8);

    // Stop the signal: timeout follows 16 cycles after the reported edge.
    t     = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(i == 0);
      t++;
      if (timeout) found = 1'b1;
    end
    checkOutput("timeout_latency", t, 16);
    checkOutput("timeout_period_held", int'(period), 8);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0);
    checkOutput("timeout_level", int'(timeout), 1);

    // First rise after timeout clears it without reporting.
    clearCounts();
    exp_period_g = 6;
    drivePeriod(3, 3);
    checkOutput("recover_timeout_clear", int'(timeout), 0);
    checkOutput("recover_no_valid", valid_seen, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    checkOutput("recover_valid", int'(valid), 1);
    checkOutput("recover_period", int'(period), 6);
    checkOutput("recover_overlap", overlap_seen, 0);

    // Reset part-way through an interval clears everything immediately.
    applyReset();
    exp_period_g = 8;
    drivePeriod(4, 4);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    checkOutput("pre_reset_period", int'(period), 8);
    applyStimulus(1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_period", int'(period), 0);
    checkOutput("midrst_valid", int'(valid), 0);
    checkOutput("midrst_timeout", int'(timeout), 0);

    // sig_in held high across release must not count as an edge.
    sig_in = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    clearCounts();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0);
    drivePeriod(4, 4);
    checkOutput("postrst_first_rise_no_valid", valid_seen, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    checkOutput("postrst_valid", int'(valid), 1);
    checkOutput("postrst_period", int'(period), 8);
    checkOutput("postrst_timeout_seen", timeout_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
